// File: rtl/ula_pkg.sv
// Shared types and helpers for the multi-cycle ULA: function codes, FSM states,
// and the predicates that steer operations between the single-cycle and iterative paths.
package ula_pkg;

    typedef enum logic [3:0] {
        F_AND = 4'd0,
        F_OR  = 4'd1,
        F_ADD = 4'd2,
        F_XOR = 4'd3,
        F_SLL = 4'd4,
        F_SRL = 4'd5,
        F_SUB = 4'd6,
        F_SLT = 4'd7,
        F_NOR = 4'd8,
        F_SRA = 4'd9,
        F_MUL = 4'd10,
        F_DIV = 4'd11,
        F_REM = 4'd12
    } func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(logic [3:0] f);
        return (f == F_MUL) || (f == F_DIV) || (f == F_REM);
    endfunction

    function automatic logic is_legal(logic [3:0] f);
        return f <= F_REM;
    endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// Shared W-step iterative datapath: unsigned shift-add multiply or restoring divide
// on magnitudes. The step result is exposed combinationally so the last step can be registered by the parent.
module ula_muldiv_iter #(
    parameter int W  = 32,
    parameter int CW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           op_div,
    input  logic [W-1:0]   mag_a,
    input  logic [W-1:0]   mag_b,
    output logic           done,
    output logic [2*W-1:0] prod,
    output logic [W-1:0]   quot,
    output logic [W-1:0]   rem
);

    logic [CW-1:0]  count;
    logic           div_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] p_q;
    logic [2*W-1:0] p_nxt;
    logic [W:0]     add_sum;
    logic [W:0]     shifted;
    logic [W-1:0]   diff;
    logic           fits;

    // Upper half is the partial product / partial remainder, lower half the multiplier / quotient.
    always_comb begin
        add_sum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, b_q} : '0);
        shifted = {p_q[2*W-1:W], p_q[W-1]};
        fits    = shifted >= {1'b0, b_q};
        diff    = shifted[W-1:0] - b_q;
        if (!div_q) begin
            p_nxt = {add_sum, p_q[W-1:1]};
        end else if (fits) begin
            p_nxt = {diff, p_q[W-2:0], 1'b1};
        end else begin
            p_nxt = {shifted[W-1:0], p_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            div_q <= 1'b0;
            b_q   <= '0;
            p_q   <= '0;
        end else if (start) begin
            count <= CW'(W);
            div_q <= op_div;
            b_q   <= mag_b;
            p_q   <= {{W{1'b0}}, mag_a};
        end else if (count != '0) begin
            count <= count - CW'(1);
            p_q   <= p_nxt;
        end
    end

    assign done = (count == CW'(1));
    assign prod = p_nxt;
    assign quot = p_nxt[W-1:0];
    assign rem  = p_nxt[2*W-1:W];

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ALU with valid/ready on both sides: single-cycle logic/arith ops,
// iterative signed MUL/DIV/REM, registered result and flags.
//   state | meaning
//   IDLE  | waiting for an operation, in_ready=1
//   BUSY  | MUL/DIV/REM iterating, in_ready=0
//   DONE  | result registers valid, held until out_ready
module ula_mc
    import ula_pkg::*;
#(
    parameter int W = 32,
    localparam int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [3:0]   func,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         div_zero,
    output logic         illegal
);

    localparam int SW = $clog2(W);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    state_t state, state_nxt;
    logic accept, special, go_multi, go_single, iter_done, b_zero, is_sub;
    logic [SW-1:0] sh;
    logic [W-1:0] b_eff, sum, mag_a, mag_b, quot, rem;
    logic [W-1:0] alu_res, mc_res;
    logic alu_ovf, alu_dz, alu_ill, mc_ovf, neg_q;
    logic [3:0] op_q;
    logic [2*W-1:0] prod, prod_fix;

    assign accept    = in_valid && in_ready;
    assign b_zero    = (in_b == '0);
    assign special   = ((func == F_DIV) || (func == F_REM)) &&
                       (b_zero || ((in_a == MIN_VAL) && (in_b == '1)));
    assign go_multi  = accept && is_multicycle(func) && !special;
    assign go_single = accept && !go_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go_multi)       state_nxt = BUSY;
                else if (go_single) state_nxt = DONE;
            end
            BUSY: if (iter_done) state_nxt = DONE;
            DONE: begin
                if (go_multi)       state_nxt = BUSY;
                else if (go_single) state_nxt = DONE;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    assign sh     = in_b[SW-1:0];
    assign is_sub = (func == F_SUB);
    assign b_eff  = is_sub ? ~in_b : in_b;
    assign sum    = in_a + b_eff + {{(W-1){1'b0}}, is_sub};

    // Single-cycle results, including the DIV/REM corner cases that bypass the iterator.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_dz  = 1'b0;
        alu_ill = 1'b0;
        case (func)
            F_AND: alu_res = in_a & in_b;
            F_OR:  alu_res = in_a | in_b;
            F_XOR: alu_res = in_a ^ in_b;
            F_NOR: alu_res = ~(in_a | in_b);
            F_ADD, F_SUB: begin
                alu_res = sum;
                alu_ovf = (in_a[W-1] == b_eff[W-1]) && (sum[W-1] != in_a[W-1]);
            end
            F_SLL: alu_res = in_a << sh;
            F_SRL: alu_res = in_a >> sh;
            F_SRA: alu_res = $signed(in_a) >>> sh;
            F_SLT: alu_res = {{(W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            F_DIV: begin
                alu_res = b_zero ? '1 : MIN_VAL;
                alu_dz  = b_zero;
                alu_ovf = !b_zero;
            end
            F_REM: begin
                alu_res = b_zero ? in_a : '0;
                alu_dz  = b_zero;
                alu_ovf = !b_zero;
            end
            default: alu_ill = !is_legal(func);
        endcase
    end

    assign mag_a = in_a[W-1] ? -in_a : in_a;
    assign mag_b = in_b[W-1] ? -in_b : in_b;

    ula_muldiv_iter #(.W(W), .CW(CW)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (go_multi),
        .op_div (func != F_MUL),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .done   (iter_done),
        .prod   (prod),
        .quot   (quot),
        .rem    (rem)
    );

    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        mc_ovf = 1'b0;
        case (op_q)
            F_MUL: begin
                mc_res = prod_fix[W-1:0];
                mc_ovf = (prod_fix[2*W-1:W] != {W{prod_fix[W-1]}});
            end
            F_DIV:   mc_res = neg_q ? -quot : quot;
            default: mc_res = neg_q ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            div_zero <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (go_multi) begin
                op_q  <= func;
                // REM takes the dividend's sign; MUL/DIV the XOR of both.
                neg_q <= (func == F_REM) ? in_a[W-1] : (in_a[W-1] ^ in_b[W-1]);
            end
            if (go_single) begin
                result   <= alu_res;
                overflow <= alu_ovf;
                zero     <= (alu_res == '0);
                div_zero <= alu_dz;
                illegal  <= alu_ill;
            end else if (iter_done) begin
                result   <= mc_res;
                overflow <= mc_ovf;
                zero     <= (mc_res == '0);
                div_zero <= 1'b0;
                illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_mc.sv
// Scoreboard bench for ula_mc: the driver queues expected results on accept,
// and a monitor compares them whenever a result is taken.
module tb_ula_mc;
    import ula_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [31:0] r;
        logic        ov;
        logic        z;
        logic        dz;
        logic        il;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [3:0]   func = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         overflow, zero, div_zero, illegal;

    exp_t  sbq[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    ula_mc #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero),
        .div_zero  (div_zero),
        .illegal   (illegal)
    );

    function automatic exp_t mk(logic [31:0] r, logic ov, logic z, logic dz, logic il);
        return '{r, ov, z, dz, il};
    endfunction

    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [3:0] f);
        logic [31:0] r;
        logic        ov;
        longint      s;
        int          sh;
        r  = '0;
        ov = 1'b0;
        sh = int'(b[4:0]);
        case (f)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                s  = longint'($signed(a)) + longint'($signed(b));
                r  = s[31:0];
                ov = (s != longint'($signed(r)));
            end
            4'd3: r = a ^ b;
            4'd4: r = a << sh;
            4'd5: r = a >> sh;
            4'd6: begin
                s  = longint'($signed(a)) - longint'($signed(b));
                r  = s[31:0];
                ov = (s != longint'($signed(r)));
            end
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: r = ~(a | b);
            4'd9: r = $signed(a) >>> sh;
            default: r = '0;
        endcase
        return '{r, ov, (r == 32'd0), 1'b0, 1'b0};
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Presents one op and returns just after the accepting edge; inputs stay driven.
    task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input exp_t e, output int waited);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        func     = f;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept timeout", nm);
        end else begin
            sbq.push_back(e);
            nq.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run1(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input exp_t e, input int exp_lat);
        int w, lat;
        issue(nm, a, b, f, e, w);
        idle_in();
        wait_valid(lat);
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every result the consumer takes against the queue head.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result got=%h", {result, overflow, zero, div_zero, illegal});
                end else begin
                    e  = sbq.pop_front();
                    nm = nq.pop_front();
                    if ({result, overflow, zero, div_zero, illegal} !== e) begin
                        errors++;
                        $display("FAIL %s got=%h exp=%h (result,ov,z,dz,il)", nm,
                                 {result, overflow, zero, div_zero, illegal}, e);
                    end
                end
            end
        end
    end

    initial begin
        int          w;
        logic [31:0] a, b;
        logic [3:0]  f;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", 64'({result, overflow, zero, div_zero, illegal}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Abort a MUL mid-flight with reset.
        issue("mul_aborted", 32'd3, 32'd4, F_MUL, mk(32'd12, 0, 0, 0, 0), w);
        idle_in();
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        sbq.delete();
        nq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run1("add_5_7",   32'd5,          32'd7,          F_ADD, mk(32'd12,         0, 0, 0, 0), 1);
        run1("add_ovf",   32'h7FFF_FFFF,  32'd1,          F_ADD, mk(32'h8000_0000,  1, 0, 0, 0), 1);
        run1("sub_zero",  32'd5,          32'd5,          F_SUB, mk(32'd0,          0, 1, 0, 0), 1);
        run1("sll_b37",   32'd1,          32'h25,         F_SLL, mk(32'd32,         0, 0, 0, 0), 1);
        run1("srl_31",    32'h8000_0000,  32'h3F,         F_SRL, mk(32'd1,          0, 0, 0, 0), 1);
        run1("sra_4",     32'h8000_0010,  32'd4,          F_SRA, mk(32'hF800_0001,  0, 0, 0, 0), 1);
        run1("slt_neg",   32'hFFFF_FFFF,  32'd1,          F_SLT, mk(32'd1,          0, 0, 0, 0), 1);
        run1("mul_neg",   32'hFFFF_FFF9,  32'd6,          F_MUL, mk(32'hFFFF_FFD6,  0, 0, 0, 0), 33);
        run1("mul_ovf",   32'h0001_0000,  32'h0001_0000,  F_MUL, mk(32'd0,          1, 1, 0, 0), 33);
        run1("div_neg",   32'hFFFF_FFF9,  32'd2,          F_DIV, mk(32'hFFFF_FFFD,  0, 0, 0, 0), 33);
        run1("rem_neg",   32'hFFFF_FFF9,  32'd2,          F_REM, mk(32'hFFFF_FFFF,  0, 0, 0, 0), 33);
        run1("div_pos",   32'd100,        32'd7,          F_DIV, mk(32'd14,         0, 0, 0, 0), 33);
        run1("rem_pos",   32'd100,        32'd7,          F_REM, mk(32'd2,          0, 0, 0, 0), 33);
        run1("div_min",   32'h8000_0000,  32'hFFFF_FFFF,  F_DIV, mk(32'h8000_0000,  1, 0, 0, 0), 1);
        run1("rem_min",   32'h8000_0000,  32'hFFFF_FFFF,  F_REM, mk(32'd0,          1, 1, 0, 0), 1);
        run1("div_by0",   32'd9,          32'd0,          F_DIV, mk(32'hFFFF_FFFF,  0, 0, 1, 0), 1);
        run1("rem_by0",   32'd9,          32'd0,          F_REM, mk(32'd9,          0, 0, 1, 0), 1);
        run1("illegal14", 32'h1234,       32'd5,          4'd14, mk(32'd0,          0, 1, 0, 1), 1);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue("bp_xor", 32'hF0F0_1234, 32'h0FF0_00FF, F_XOR, mk(32'hFF00_12CB, 0, 0, 0, 0), w);
        idle_in();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 64'({out_valid, in_ready, result, overflow, zero, div_zero, illegal}),
                  64'({1'b1, 1'b0, 32'hFF00_12CB, 4'b0000}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue("bp_and", 32'hFFFF_0000, 32'h1234_5678, F_AND, mk(32'h1234_0000, 0, 0, 0, 0), w);
        idle_in();
        check("bp_same_cycle_accept", 64'(w), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back random single-cycle ops: one accept per cycle.
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            f = 4'($urandom_range(0, 9));
            issue($sformatf("stream%0d_f%0d", i, f), a, b, f, model(a, b, f), w);
            check("stream_rate", 64'(w), 64'd0);
        end
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
